uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART RX serial interface.
- Accepts one character per pulse of the receiver's done tick and holds it until the MMIO register interface pops it.
- Provides full/empty/level status. The full flag feeds back to the receiver's overrun input.
- Keeps a sticky overrun flag for characters that arrive while the buffer is full and are dropped.

Parameters:
DATA_BITS, 8, width of one received character
DEPTH, 16, number of entries; power of two, minimum 2
CW, $clog2(DEPTH)+1, width of level/pointer fields (derived, localparam)

Ports:
clk  input  1  system clock
arst_n  input  1  asynchronous active-low reset
wr_en  input  1  push strobe, driven by receiver done tick (single-cycle pulse)
wr_data  input  DATA_BITS  received character, valid when wr_en=1
rd_en  input  1  pop strobe from register interface
rd_data  output  DATA_BITS  head entry (first-word fall-through)
empty  output  1  no entries stored
full  output  1  DEPTH entries stored; connects to the receiver's full input
level  output  CW  number of stored entries, 0..DEPTH
overrun  output  1  sticky: a push was dropped
clr_overrun  input  1  clears overrun

Behaviour:
- Reset is arst_n, asynchronous, active-low; clock is clk. All state is rising-edge.
- Reset values: rd_ptr=0, wr_ptr=0, level=0, empty=1, full=0, overrun=0, rd_data=0. Storage array is not reset.
- Pointers are CW bits wide: the low $clog2(DEPTH) bits index storage, the MSB is a wrap bit.
- empty = (wr_ptr==rd_ptr). full = (index bits equal && wrap bits differ). level = wr_ptr-rd_ptr, modulo 2^CW.
- empty, full and level are combinational from the registered pointers and change the cycle after the push/pop edge.
- rd_data = mem[rd_ptr index] when !empty, else all zeros. No read latency; head is visible as soon as empty falls.
- do_pop = rd_en && !empty. Pop advances rd_ptr by 1. rd_en while empty is ignored: no pointer change, no error.
- do_push = wr_en && (!full || do_pop). Push writes wr_data at the wr_ptr index and advances wr_ptr by 1.
- Push while full, no pop in the same cycle: wr_data is discarded, pointers unchanged, overrun set to 1 next cycle.
- Push and pop in the same cycle:
  - Non-empty, non-full: both occur; level unchanged.
  - Full: both occur; new data goes into the slot freed by the pop; no overrun; full stays 1.
  - Empty: pop ignored, push occurs; level becomes 1.
- Wrap-around: the index rolls from DEPTH-1 to 0 and the wrap bit toggles. Continuous streaming never corrupts ordering.
- overrun: set by a dropped push, cleared by clr_overrun. If both occur in the same cycle, set wins. It remains 1 until cleared, regardless of later pops.
- Reset mid-operation: all pointers and flags return to reset values immediately. Stored data is lost. A wr_en coincident with reset deassertion is not stored.
- Level arithmetic never saturates beyond DEPTH; this is guaranteed by the full gating.

Optional Feature:
- UART_RX_FIFO_THRESH_EN defined:
  - Adds input thresh (CW bits) and output thresh_irq (1 bit, registered, reset 0).
  - thresh_irq = 1 on the cycle after level >= thresh with thresh != 0, else 0.
  - Recomputed every cycle, no stickiness; thresh=0 keeps it 0.
- Not defined: neither port exists, no threshold logic is synthesised, all other behaviour is identical.

Test Plan:
- After reset, push 0xA5 (one wr_en pulse) -> next cycle empty=0, level=1, rd_data=0xA5; pulse rd_en -> empty=1, rd_data=0x00.
- Push 16 values 0x00..0x0F with DEPTH=16 -> full=1, level=16; 17th push 0xFF -> dropped, overrun=1; pop all 16 -> data 0x00..0x0F in order, 0xFF never appears, overrun stays 1 until a clr_overrun pulse.
- With full, assert wr_en=1 (0x55) and rd_en=1 together -> rd_data advances, level stays 16, overrun stays 0; 0x55 emerges last.
- Stream 40 pushes interleaved with pops, keeping level between 1 and 3 -> output sequence equals input sequence across 2+ pointer wraps; full never asserts.
- Assert clr_overrun in the same cycle as a dropped push -> overrun=1. With empty, pulse rd_en -> level stays 0, no underflow (level never reads 2^CW-1).
- (UART_RX_FIFO_THRESH_EN) thresh=4: push 3 values -> thresh_irq=0; 4th push -> thresh_irq=1 one cycle after level=4; pop one -> thresh_irq=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side character buffer between the UART receiver and the
// register interface. First-word fall-through, with a sticky overrun flag for
// characters dropped while the buffer is full.
//
// Ports:
//   clk          system clock (rising edge)
//   arst_n       asynchronous active-low reset
//   wr_en        push strobe (receiver done tick)
//   wr_data      received character, valid with wr_en
//   rd_en        pop strobe from the register interface
//   rd_data      head entry, zero while empty
//   empty        no entries stored
//   full         DEPTH entries stored (feeds the receiver's overrun input)
//   level        number of stored entries, 0..DEPTH
//   overrun      sticky: a push was dropped
//   clr_overrun  clears overrun (a coincident drop wins)
//
// Optional feature, enabled by defining UART_RX_FIFO_THRESH_EN:
//   thresh       level threshold, 0 disables
//   thresh_irq   registered, high the cycle after level >= thresh (thresh != 0)

module uart_rx_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16,
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [CW-1:0]        level,
  output logic                 overrun,
  input  logic                 clr_overrun
`ifdef UART_RX_FIFO_THRESH_EN
  ,
  input  logic [CW-1:0]        thresh,
  output logic                 thresh_irq
`endif
);

  // Index width; the pointer MSB above it is the wrap bit.
  localparam int unsigned AW = CW - 1;

  logic [CW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_idx, rd_idx;
  logic                 overrun_q, overrun_d;
  logic                 do_push, do_pop;
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // Status is purely a function of the registered pointers.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_idx == rd_idx) && (wr_ptr_q[CW-1] != rd_ptr_q[CW-1]);
    level = wr_ptr_q - rd_ptr_q;
  end

  // A pop in the same cycle frees a slot, so a push into a full buffer is
  // still accepted when it coincides with a pop.
  always_comb begin
    do_pop  = rd_en && !empty;
    do_push = wr_en && (!full || do_pop);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end
  end

  // Set has priority over clear so a drop is never lost to a coincident clear.
  always_comb begin
    overrun_d = overrun_q;
    if (wr_en && !do_push) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage carries no reset; stale contents are masked by empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (!empty) begin
      rd_data = mem_q[rd_idx];
    end
  end

  assign overrun = overrun_q;

`ifdef UART_RX_FIFO_THRESH_EN
  logic thresh_irq_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      thresh_irq_q <= 1'b0;
    end else begin
      thresh_irq_q <= (thresh != '0) && (level >= thresh);
    end
  end

  assign thresh_irq = thresh_irq_q;
`endif

endmodule
